// File: rtl/mux2_rr_arbiter_pkg.sv
// Shared encodings and the arbitration decision for the 2:1 round-robin arbiter.
package mux2_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_A = 2'd1,
    ST_GNT_B = 2'd2
  } state_e;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // Picks the next grant from two requests; prio names the tie winner.
  function automatic state_e arbitrate(input logic req_a, input logic req_b, input logic prio);
    state_e nxt;
    if (req_a && req_b) nxt = (prio == SEL_B) ? ST_GNT_B : ST_GNT_A;
    else if (req_a)     nxt = ST_GNT_A;
    else if (req_b)     nxt = ST_GNT_B;
    else                nxt = ST_IDLE;
    return nxt;
  endfunction

endpackage

// File: rtl/mux2_rr_arbiter_datapath.sv
// Shared 2:1 output mux of {valid, data, last}; en gates valid so no beat leaks while idle.
module mux2_datapath #(
  parameter int WIDTH = 8
) (
  input  logic             sel,
  input  logic             en,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_last,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_last,
  output logic             y_valid,
  output logic [WIDTH-1:0] y_data,
  output logic             y_last
);

  assign y_valid = en & (sel ? b_valid : a_valid);
  assign y_data  = sel ? b_data : a_data;
  assign y_last  = sel ? b_last : a_last;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin packet arbiter for two streaming sources sharing one output channel,
// with an optional burst cap that splits long packets so neither source starves.
module mux2_rr_arbiter
  import mux2_rr_arbiter_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 16,
  parameter int CNT_W     = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_last,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_last,
  output logic             b_ready,
  output logic             y_valid,
  output logic [WIDTH-1:0] y_data,
  output logic             y_last,
  input  logic             y_ready,
  output logic             sel,
  output logic             busy
);

  localparam bit               BURST_EN   = (MAX_BURST != 0);
  localparam logic [CNT_W-1:0] BURST_LAST = BURST_EN ? CNT_W'(MAX_BURST - 1) : '0;

  state_e           state_q, state_d;
  logic             sel_q, sel_d;
  logic             busy_q, busy_d;
  logic             prio_q, prio_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic grant_a, grant_b, xfer, release_beat;

  assign grant_a = (state_q == ST_GNT_A);
  assign grant_b = (state_q == ST_GNT_B);

  mux2_datapath #(.WIDTH(WIDTH)) u_datapath (
    .sel     (sel_q),
    .en      (grant_a | grant_b),
    .a_valid (a_valid),
    .a_data  (a_data),
    .a_last  (a_last),
    .b_valid (b_valid),
    .b_data  (b_data),
    .b_last  (b_last),
    .y_valid (y_valid),
    .y_data  (y_data),
    .y_last  (y_last)
  );

  assign a_ready      = grant_a & y_ready;
  assign b_ready      = grant_b & y_ready;
  assign xfer         = y_valid & y_ready;
  assign release_beat = xfer & (y_last | (BURST_EN && (cnt_q == BURST_LAST)));
  assign sel          = sel_q;
  assign busy         = busy_q;

  // The releasing source only re-requests when its packet was cut short by the
  // burst cap; after its last beat it must let the other source in or go idle.
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves it unassigned (no latch).
    state_d = state_q;
    sel_d   = sel_q;
    prio_d  = prio_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: state_d = arbitrate(a_valid, b_valid, prio_q);
      ST_GNT_A: begin
        if (xfer) cnt_d = cnt_q + CNT_W'(1);
        if (release_beat) begin
          cnt_d   = '0;
          prio_d  = SEL_B;
          state_d = arbitrate(a_valid & ~a_last, b_valid, SEL_B);
        end
      end
      ST_GNT_B: begin
        if (xfer) cnt_d = cnt_q + CNT_W'(1);
        if (release_beat) begin
          cnt_d   = '0;
          prio_d  = SEL_A;
          state_d = arbitrate(a_valid, b_valid & ~b_last, SEL_A);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_GNT_A)      sel_d = SEL_A;
    else if (state_d == ST_GNT_B) sel_d = SEL_B;
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q <= ST_IDLE;
      sel_q   <= SEL_A;
      busy_q  <= 1'b0;
      prio_q  <= SEL_A;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed bench for mux2_rr_arbiter built with a burst cap of 4 beats.
module tb_mux2_rr_arbiter;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             a_valid, a_last, a_ready;
  logic [WIDTH-1:0] a_data;
  logic             b_valid, b_last, b_ready;
  logic [WIDTH-1:0] b_data;
  logic             y_valid, y_last, y_ready;
  logic [WIDTH-1:0] y_data;
  logic             sel, busy;

  int checks = 0;
  int errors = 0;

  mux2_rr_arbiter #(.WIDTH(WIDTH), .MAX_BURST(4), .CNT_W(3)) dut (
    .clk     (clk),
    .reset   (reset),
    .a_valid (a_valid),
    .a_data  (a_data),
    .a_last  (a_last),
    .a_ready (a_ready),
    .b_valid (b_valid),
    .b_data  (b_data),
    .b_last  (b_last),
    .b_ready (b_ready),
    .y_valid (y_valid),
    .y_data  (y_data),
    .y_last  (y_last),
    .y_ready (y_ready),
    .sel     (sel),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one cycle of inputs, checks outputs at the falling edge, then steps past the next rising edge.
  task automatic cyc(input string tag,
                     input logic av, input logic [7:0] ad, input logic al,
                     input logic bv, input logic [7:0] bd, input logic bl,
                     input logic yr,
                     input logic e_sel, input logic e_busy, input logic e_yv,
                     input logic [7:0] e_yd, input logic e_yl,
                     input logic e_ar, input logic e_br, input int e_cnt);
    a_valid = av; a_data = ad; a_last = al;
    b_valid = bv; b_data = bd; b_last = bl;
    y_ready = yr;
    @(negedge clk);
    chk({tag, ".sel"},     32'(sel),     32'(e_sel));
    chk({tag, ".busy"},    32'(busy),    32'(e_busy));
    chk({tag, ".y_valid"}, 32'(y_valid), 32'(e_yv));
    chk({tag, ".a_ready"}, 32'(a_ready), 32'(e_ar));
    chk({tag, ".b_ready"}, 32'(b_ready), 32'(e_br));
    chk({tag, ".cnt"},     32'(dut.cnt_q), 32'(e_cnt));
    if (e_yv) begin
      chk({tag, ".y_data"}, 32'(y_data), 32'(e_yd));
      chk({tag, ".y_last"}, 32'(y_last), 32'(e_yl));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    a_valid = 1'b0; a_data = '0; a_last = 1'b0;
    b_valid = 1'b0; b_data = '0; b_last = 1'b0;
    y_ready = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    a_valid = 1'b0; a_data = '0; a_last = 1'b0;
    b_valid = 1'b0; b_data = '0; b_last = 1'b0;
    y_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("rst.prio", 32'(dut.prio_q), 32'(0));
    cyc("rst", 0,8'h00,0, 0,8'h00,0, 1,  0,0,0,8'h00,0,0,0, 0);
    reset = 1'b0;

    // A alone, 3-beat packet
    cyc("t1.c0", 1,8'h11,0, 0,8'h00,0, 1,  0,0,0,8'h00,0,0,0, 0);
    cyc("t1.c1", 1,8'h11,0, 0,8'h00,0, 1,  0,1,1,8'h11,0,1,0, 0);
    cyc("t1.c2", 1,8'h22,0, 0,8'h00,0, 1,  0,1,1,8'h22,0,1,0, 1);
    cyc("t1.c3", 1,8'h33,1, 0,8'h00,0, 1,  0,1,1,8'h33,1,1,0, 2);
    cyc("t1.c4", 0,8'h00,0, 0,8'h00,0, 1,  0,0,0,8'h00,0,0,0, 0);

    // Both sources, alternating 2-beat packets
    do_reset();
    cyc("t2.c0", 1,8'hA0,0, 1,8'hB0,0, 1,  0,0,0,8'h00,0,0,0, 0);
    cyc("t2.c1", 1,8'hA0,0, 1,8'hB0,0, 1,  0,1,1,8'hA0,0,1,0, 0);
    cyc("t2.c2", 1,8'hA1,1, 1,8'hB0,0, 1,  0,1,1,8'hA1,1,1,0, 1);
    cyc("t2.c3", 1,8'hA2,0, 1,8'hB0,0, 1,  1,1,1,8'hB0,0,0,1, 0);
    cyc("t2.c4", 1,8'hA2,0, 1,8'hB1,1, 1,  1,1,1,8'hB1,1,0,1, 1);
    cyc("t2.c5", 1,8'hA2,0, 1,8'hB2,0, 1,  0,1,1,8'hA2,0,1,0, 0);
    cyc("t2.c6", 1,8'hA3,1, 1,8'hB2,0, 1,  0,1,1,8'hA3,1,1,0, 1);
    cyc("t2.c7", 1,8'hA4,0, 1,8'hB2,0, 1,  1,1,1,8'hB2,0,0,1, 0);
    cyc("t2.c8", 1,8'hA4,0, 1,8'hB3,1, 1,  1,1,1,8'hB3,1,0,1, 1);

    // Burst cap 4: A sends 10 beats, B always has 2-beat packets
    do_reset();
    cyc("t3.c0",  1,8'h40,0, 1,8'hC0,0, 1,  0,0,0,8'h00,0,0,0, 0);
    cyc("t3.c1",  1,8'h40,0, 1,8'hC0,0, 1,  0,1,1,8'h40,0,1,0, 0);
    cyc("t3.c2",  1,8'h41,0, 1,8'hC0,0, 1,  0,1,1,8'h41,0,1,0, 1);
    cyc("t3.c3",  1,8'h42,0, 1,8'hC0,0, 1,  0,1,1,8'h42,0,1,0, 2);
    cyc("t3.c4",  1,8'h43,0, 1,8'hC0,0, 1,  0,1,1,8'h43,0,1,0, 3);
    cyc("t3.c5",  1,8'h44,0, 1,8'hC0,0, 1,  1,1,1,8'hC0,0,0,1, 0);
    cyc("t3.c6",  1,8'h44,0, 1,8'hC1,1, 1,  1,1,1,8'hC1,1,0,1, 1);
    cyc("t3.c7",  1,8'h44,0, 1,8'hC2,0, 1,  0,1,1,8'h44,0,1,0, 0);
    cyc("t3.c8",  1,8'h45,0, 1,8'hC2,0, 1,  0,1,1,8'h45,0,1,0, 1);
    cyc("t3.c9",  1,8'h46,0, 1,8'hC2,0, 1,  0,1,1,8'h46,0,1,0, 2);
    cyc("t3.c10", 1,8'h47,0, 1,8'hC2,0, 1,  0,1,1,8'h47,0,1,0, 3);
    cyc("t3.c11", 1,8'h48,0, 1,8'hC2,0, 1,  1,1,1,8'hC2,0,0,1, 0);
    cyc("t3.c12", 1,8'h48,0, 1,8'hC3,1, 1,  1,1,1,8'hC3,1,0,1, 1);
    cyc("t3.c13", 1,8'h48,0, 1,8'hC4,0, 1,  0,1,1,8'h48,0,1,0, 0);
    cyc("t3.c14", 1,8'h49,1, 1,8'hC4,0, 1,  0,1,1,8'h49,1,1,0, 1);
    cyc("t3.c15", 0,8'h00,0, 1,8'hC4,0, 1,  1,1,1,8'hC4,0,0,1, 0);

    // Backpressure during a 3-beat B packet
    do_reset();
    cyc("t4.c0", 0,8'h00,0, 1,8'h50,0, 1,  0,0,0,8'h00,0,0,0, 0);
    cyc("t4.c1", 0,8'h00,0, 1,8'h50,0, 1,  1,1,1,8'h50,0,0,1, 0);
    cyc("t4.c2", 0,8'h00,0, 1,8'h51,0, 0,  1,1,1,8'h51,0,0,0, 1);
    cyc("t4.c3", 0,8'h00,0, 1,8'h51,0, 1,  1,1,1,8'h51,0,0,1, 1);
    cyc("t4.c4", 0,8'h00,0, 1,8'h52,1, 0,  1,1,1,8'h52,1,0,0, 2);
    cyc("t4.c5", 0,8'h00,0, 1,8'h52,1, 1,  1,1,1,8'h52,1,0,1, 2);
    cyc("t4.c6", 0,8'h00,0, 0,8'h00,0, 1,  1,0,0,8'h00,0,0,0, 0);
    chk("t4.prio", 32'(dut.prio_q), 32'(0));

    // Reset pulse on beat 2 of a B packet, with prio pointing at B
    do_reset();
    cyc("t5.c0", 1,8'h60,1, 1,8'h70,0, 1,  0,0,0,8'h00,0,0,0, 0);
    cyc("t5.c1", 1,8'h60,1, 1,8'h70,0, 1,  0,1,1,8'h60,1,1,0, 0);
    cyc("t5.c2", 0,8'h00,0, 1,8'h70,0, 1,  1,1,1,8'h70,0,0,1, 0);
    chk("t5.prio_pre", 32'(dut.prio_q), 32'(1));
    reset = 1'b1;
    cyc("t5.c3", 0,8'h00,0, 1,8'h71,0, 1,  1,1,1,8'h71,0,0,1, 1);
    reset = 1'b0;
    chk("t5.prio_post", 32'(dut.prio_q), 32'(0));
    cyc("t5.c4", 1,8'h61,0, 1,8'h72,0, 1,  0,0,0,8'h00,0,0,0, 0);
    cyc("t5.c5", 1,8'h61,0, 1,8'h72,0, 1,  0,1,1,8'h61,0,1,0, 0);

    // Granted A stalls for 3 cycles while B waits
    do_reset();
    cyc("t6.c0", 1,8'h80,0, 1,8'h90,0, 1,  0,0,0,8'h00,0,0,0, 0);
    cyc("t6.c1", 1,8'h80,0, 1,8'h90,0, 1,  0,1,1,8'h80,0,1,0, 0);
    cyc("t6.c2", 1,8'h81,0, 1,8'h90,0, 1,  0,1,1,8'h81,0,1,0, 1);
    cyc("t6.c3", 0,8'h00,0, 1,8'h90,0, 1,  0,1,0,8'h00,0,1,0, 2);
    cyc("t6.c4", 0,8'h00,0, 1,8'h90,0, 1,  0,1,0,8'h00,0,1,0, 2);
    cyc("t6.c5", 0,8'h00,0, 1,8'h90,0, 1,  0,1,0,8'h00,0,1,0, 2);
    cyc("t6.c6", 1,8'h82,1, 1,8'h90,0, 1,  0,1,1,8'h82,1,1,0, 2);
    cyc("t6.c7", 0,8'h00,0, 1,8'h90,0, 1,  1,1,1,8'h90,0,0,1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
